// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: pipeline stall/flush controller for load-use, fetch wait, data-memory freeze and branch flush.
// Ports: clk, reset_n (sync, active-low); IF_ID_*/ID_EX_* describe the ID and EX instructions;
// EX_branch_taken resolves a taken branch; imem_busy/dmem_busy report memory wait states.
// Outputs: combined_stall, hazard_stall cause code, EX_clear_IF_ID flush, PC/IF_ID write enables,
// sticky mem_timeout_err. Defining STALL_PERF_CNT_EN adds stall_cycles and flush_count counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        IF_ID_enable_out,
  input  logic [4:0]  IF_ID_Rs1,
  input  logic [4:0]  IF_ID_Rs2,
  input  logic        ID_EX_enable_out,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rd,
  input  logic        EX_branch_taken,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  output logic        combined_stall,
  output logic [1:0]  hazard_stall,
  output logic        EX_clear_IF_ID,
  output logic        PC_write_en,
  output logic        IF_ID_write_en,
  output logic        mem_timeout_err
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);
  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_FREEZE, FLUSH_PEND} state_t;
  state_t state, next_state;
  logic flush_pending;
  logic [15:0] freeze_cnt;
  logic [16:0] freeze_inc;
  logic load_use, lu_eff, freezing, entering;
  logic [1:0] hs;
  logic clr;
  assign load_use = ID_EX_enable_out && ID_EX_MemRead && ID_EX_Rd != 5'd0 && IF_ID_enable_out &&
                    (ID_EX_Rd == IF_ID_Rs1 || ID_EX_Rd == IF_ID_Rs2);
  // the bubble cycle masks the hazard it was inserted for
  assign lu_eff = load_use && state != LU_BUBBLE;
  assign freezing = state == MEM_FREEZE && dmem_busy;
  assign entering = state != MEM_FREEZE && next_state == MEM_FREEZE;
  assign freeze_inc = {1'b0, freeze_cnt} + 17'd1;
  always_ff @(posedge clk)
    if (!reset_n) state <= RUN;
    else state <= next_state;
  // a freeze exit with a remembered branch detours through FLUSH_PEND; otherwise normal RUN rules apply
  always_comb
    next_state = dmem_busy ? MEM_FREEZE
               : state == FLUSH_PEND ? RUN
               : (state == MEM_FREEZE && flush_pending) ? FLUSH_PEND
               : (!EX_branch_taken && lu_eff) ? LU_BUBBLE : RUN;
  // outputs are forced idle while reset_n is low, whatever the inputs
  always_comb begin
    hs = dmem_busy ? 2'b10
       : (state == FLUSH_PEND || EX_branch_taken) ? 2'b00
       : lu_eff ? 2'b01
       : imem_busy ? 2'b11 : 2'b00;
    clr = !dmem_busy && (state == FLUSH_PEND || EX_branch_taken);
    hazard_stall = reset_n ? hs : 2'b00;
    combined_stall = reset_n && hs != 2'b00;
    EX_clear_IF_ID = reset_n && clr;
    PC_write_en = !combined_stall;
    IF_ID_write_en = !combined_stall;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      flush_pending <= 1'b0;
      freeze_cnt <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      flush_pending <= dmem_busy ? flush_pending | EX_branch_taken
                     : state == FLUSH_PEND ? 1'b0 : flush_pending;
      freeze_cnt <= entering ? 16'd0
                  : (freezing && freeze_cnt != 16'hFFFF) ? freeze_inc[15:0] : freeze_cnt;
      if (freezing && 32'(freeze_inc) >= MEM_TIMEOUT) mem_timeout_err <= 1'b1;
    end
`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk)
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(combined_stall && stall_cycles != 32'hFFFF_FFFF);
      flush_count <= flush_count + 32'(EX_clear_IF_ID && flush_count != 32'hFFFF_FFFF);
    end
`endif
endmodule
